// File: rtl/fp_add_sequencer.sv
// ---------------------------------------------------------------------------
// fp_add_sequencer
//
// Control sequencer for a multi-cycle floating-point adder.  Accepts one
// operand pair (as classification flags plus an effective-subtract bit),
// resolves IEEE special cases up front, and otherwise steps the datapath
// through align / add / normalize / round before presenting the result.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready only in IDLE)
//   a_*, b_*            operand classification flags: zero, inf, nan, snan
//   eff_sub             operand signs make this an effective subtraction
//   align_en .. round_en  datapath stage enables, at most one high
//   norm_done           normalizer reports leading one in position
//   result_sel          00 datapath, 01 quiet NaN, 10 infinity, 11 zero
//   invalid             IEEE invalid-operation flag, valid with out_valid
//   out_valid/out_ready result handshake
//   busy                high in every state except IDLE
//   ops_done            count of completed results, wraps at 16 bits
//
// State table
//   IDLE     | waiting for an operand pair
//   CLASSIFY | resolve special operands, pick result source
//   ALIGN    | exponent alignment (one cycle)
//   ADD      | mantissa add/subtract (one cycle)
//   NORM     | normalize until norm_done or 24 cycles
//   ROUND    | rounding (one cycle)
//   DONE     | result presented, waiting for out_ready
// ---------------------------------------------------------------------------
module fp_add_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        a_zero,
    input  logic        a_inf,
    input  logic        a_nan,
    input  logic        a_snan,
    input  logic        b_zero,
    input  logic        b_inf,
    input  logic        b_nan,
    input  logic        b_snan,
    input  logic        eff_sub,
    output logic        align_en,
    output logic        add_en,
    output logic        norm_en,
    output logic        round_en,
    input  logic        norm_done,
    output logic [1:0]  result_sel,
    output logic        invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] ops_done
);

    typedef enum logic [2:0] {
        IDLE, CLASSIFY, ALIGN, ADD, NORM, ROUND, DONE
    } state_t;

    localparam logic [4:0] NORM_LAST = 5'd23;

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_QNAN = 2'b01;
    localparam logic [1:0] SEL_INF  = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    state_t     state;
    logic [4:0] norm_cnt;

    logic a_zero_q, a_inf_q, a_nan_q, a_snan_q;
    logic b_zero_q, b_inf_q, b_nan_q, b_snan_q;
    logic eff_sub_q;

    logic [1:0] cls_sel;
    logic       cls_inv;

    // Special-case priority: signalling NaN beats quiet NaN beats inf-inf
    // beats plain infinity beats exact zero sum.
    always_comb begin
        cls_sel = SEL_DATA;
        cls_inv = 1'b0;
        if (a_snan_q || b_snan_q) begin
            cls_sel = SEL_QNAN;
            cls_inv = 1'b1;
        end else if (a_nan_q || b_nan_q) begin
            cls_sel = SEL_QNAN;
        end else if (a_inf_q && b_inf_q && eff_sub_q) begin
            cls_sel = SEL_QNAN;
            cls_inv = 1'b1;
        end else if (a_inf_q || b_inf_q) begin
            cls_sel = SEL_INF;
        end else if (a_zero_q && b_zero_q) begin
            cls_sel = SEL_ZERO;
        end
    end

    // All outputs are registered: each is set on the edge that enters the
    // state it belongs to, so enables line up exactly with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            align_en   <= 1'b0;
            add_en     <= 1'b0;
            norm_en    <= 1'b0;
            round_en   <= 1'b0;
            result_sel <= SEL_DATA;
            invalid    <= 1'b0;
            norm_cnt   <= 5'd0;
            ops_done   <= 16'd0;
            a_zero_q   <= 1'b0;
            a_inf_q    <= 1'b0;
            a_nan_q    <= 1'b0;
            a_snan_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            b_inf_q    <= 1'b0;
            b_nan_q    <= 1'b0;
            b_snan_q   <= 1'b0;
            eff_sub_q  <= 1'b0;
        end else begin
            align_en <= 1'b0;
            add_en   <= 1'b0;
            norm_en  <= 1'b0;
            round_en <= 1'b0;

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_zero_q  <= a_zero;
                        a_inf_q   <= a_inf;
                        a_nan_q   <= a_nan;
                        a_snan_q  <= a_snan;
                        b_zero_q  <= b_zero;
                        b_inf_q   <= b_inf;
                        b_nan_q   <= b_nan;
                        b_snan_q  <= b_snan;
                        eff_sub_q <= eff_sub;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CLASSIFY;
                    end
                end

                CLASSIFY: begin
                    result_sel <= cls_sel;
                    invalid    <= cls_inv;
                    if (cls_sel != SEL_DATA) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        align_en <= 1'b1;
                        state    <= ALIGN;
                    end
                end

                ALIGN: begin
                    add_en <= 1'b1;
                    state  <= ADD;
                end

                ADD: begin
                    norm_en  <= 1'b1;
                    norm_cnt <= 5'd0;
                    state    <= NORM;
                end

                NORM: begin
                    norm_cnt <= norm_cnt + 5'd1;
                    if (norm_done || norm_cnt == NORM_LAST) begin
                        round_en <= 1'b1;
                        state    <= ROUND;
                    end else begin
                        norm_en <= 1'b1;
                    end
                end

                ROUND: begin
                    out_valid <= 1'b1;
                    state     <= DONE;
                end

                DONE: begin
                    // in_ready rises only after this edge, so no new
                    // operand can be taken in the output handshake cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        ops_done  <= ops_done + 16'd1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_sequencer.sv
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        a_zero = 1'b0, a_inf = 1'b0, a_nan = 1'b0, a_snan = 1'b0;
    logic        b_zero = 1'b0, b_inf = 1'b0, b_nan = 1'b0, b_snan = 1'b0;
    logic        eff_sub = 1'b0;
    logic        align_en, add_en, norm_en, round_en;
    logic        norm_done = 1'b0;
    logic [1:0]  result_sel;
    logic        invalid;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic [15:0] ops_done;

    fp_add_sequencer dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan), .a_snan(a_snan),
        .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan), .b_snan(b_snan),
        .eff_sub(eff_sub),
        .align_en(align_en), .add_en(add_en), .norm_en(norm_en), .round_en(round_en),
        .norm_done(norm_done), .result_sel(result_sel), .invalid(invalid),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       inv;
        int         lat;
        int         n;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_ops = 16'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Flag nibble layout: [3]=snan [2]=nan [1]=inf [0]=zero
    function automatic void model(input logic [3:0] fa, input logic [3:0] fb, input logic es,
                                  output logic [1:0] sel, output logic inv);
        sel = 2'b00;
        inv = 1'b0;
        if (fa[3] | fb[3])                 begin sel = 2'b01; inv = 1'b1; end
        else if (fa[2] | fb[2])            sel = 2'b01;
        else if (fa[1] & fb[1] & es)       begin sel = 2'b01; inv = 1'b1; end
        else if (fa[1] | fb[1])            sel = 2'b10;
        else if (fa[0] & fb[0])            sel = 2'b11;
    endfunction

    // Expected {align,add,norm,round} for cycle c after the input handshake.
    function automatic logic [3:0] exp_en(input int c, input logic [1:0] sel, input int n);
        if (sel != 2'b00)                 return 4'b0000;
        if (c == 2)                       return 4'b1000;
        if (c == 3)                       return 4'b0100;
        if (c >= 4 && c <= 3 + n)         return 4'b0010;
        if (c == 4 + n)                   return 4'b0001;
        return 4'b0000;
    endfunction

    task automatic drive_flags(input logic [3:0] fa, input logic [3:0] fb, input logic es);
        {a_snan, a_nan, a_inf, a_zero} = fa;
        {b_snan, b_nan, b_inf, b_zero} = fb;
        eff_sub = es;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        norm_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_ops = 16'd0;
        sb.delete();
    endtask

    // One operand pair end to end. n_norm = NORM cycle on which norm_done
    // is raised (0 = never); hold = DONE cycles with out_ready low.
    task automatic run_op(input logic [3:0] fa, input logic [3:0] fb, input logic es,
                          input int n_norm, input int hold);
        exp_t        e;
        exp_t        got_e;
        int          cyc;
        int          norm_seen;
        bit          got;
        logic [1:0]  sel0;
        logic        inv0;

        model(fa, fb, es, e.sel, e.inv);
        e.n   = (n_norm == 0 || n_norm > 24) ? 24 : n_norm;
        e.lat = (e.sel != 2'b00) ? 2 : 5 + e.n;

        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        drive_flags(fa, fb, es);
        @(posedge clk);
        sb.push_back(e);
        #1;
        // Inputs toggled while busy must be ignored.
        drive_flags(4'($urandom), 4'($urandom), 1'($urandom));

        cyc = 0;
        norm_seen = 0;
        got = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            check("stage_en", {align_en, add_en, norm_en, round_en}, exp_en(cyc, e.sel, e.n));
            if (norm_en) begin
                norm_seen++;
                norm_done = (n_norm != 0 && norm_seen == n_norm);
            end else begin
                norm_done = 1'b0;
            end
            if (out_valid) got = 1;
            else drive_flags(4'($urandom), 4'($urandom), 1'($urandom));
        end
        norm_done = 1'b0;
        check("out_valid_seen", got, 1);
        if (!got) begin
            do_reset();
            return;
        end

        got_e = sb.pop_front();
        check("latency", cyc, got_e.lat);
        check("result_sel", result_sel, got_e.sel);
        check("invalid", invalid, got_e.inv);
        check("busy_done", busy, 1);
        sel0 = result_sel;
        inv0 = invalid;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_sel", result_sel, sel0);
            check("hold_inv", invalid, inv0);
            check("hold_ops", ops_done, exp_ops);
            check("hold_in_ready", in_ready, 0);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_ops = exp_ops + 16'd1;
        @(negedge clk);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("ops_done", ops_done, exp_ops);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_enables", {align_en, add_en, norm_en, round_en}, 0);
        check("rst_sel", result_sel, 0);
        check("rst_invalid", invalid, 0);
        check("rst_ops", ops_done, 0);
        reset = 1'b0;

        run_op(4'b0000, 4'b0000, 1'b0, 1, 0);   // plain add, one NORM cycle
        run_op(4'b1000, 4'b0010, 1'b0, 1, 0);   // snan + inf
        run_op(4'b0010, 4'b0010, 1'b1, 1, 0);   // inf - inf
        run_op(4'b0010, 4'b0010, 1'b0, 1, 0);   // inf + inf
        run_op(4'b0000, 4'b0000, 1'b1, 0, 0);   // norm_done never comes
        run_op(4'b0000, 4'b0000, 1'b0, 5, 5);   // backpressure in DONE
        run_op(4'b0100, 4'b0000, 1'b0, 1, 2);   // quiet NaN
        run_op(4'b0001, 4'b0001, 1'b1, 1, 0);   // zero + zero
        run_op(4'b0001, 4'b0000, 1'b0, 2, 0);   // single zero goes down datapath
        run_op(4'b0100, 4'b1000, 1'b1, 1, 0);   // nan + snan
        run_op(4'b0010, 4'b0001, 1'b1, 1, 1);   // inf + zero
        run_op(4'b0000, 4'b0000, 1'b0, 24, 0);  // norm_done on the last NORM cycle

        // Reset during the third NORM cycle discards the pending result.
        begin
            int seen = 0;
            int cyc = 0;
            @(negedge clk);
            in_valid = 1'b1;
            drive_flags(4'b0000, 4'b0000, 1'b0);
            @(posedge clk);
            #1 in_valid = 1'b0;
            while (seen < 3 && cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (norm_en) seen++;
            end
            check("reach_norm3", seen, 3);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            exp_ops = 16'd0;
            check("mid_rst_out_valid", out_valid, 0);
            check("mid_rst_in_ready", in_ready, 1);
            check("mid_rst_busy", busy, 0);
            check("mid_rst_enables", {align_en, add_en, norm_en, round_en}, 0);
            check("mid_rst_ops", ops_done, exp_ops);
        end

        run_op(4'b0000, 4'b0000, 1'b0, 3, 0);   // clean op after reset

        // Counter wrap from 0xFFFF.
        @(negedge clk);
        force dut.ops_done = 16'hFFFF;
        @(negedge clk);
        release dut.ops_done;
        exp_ops = 16'hFFFF;
        check("ops_preload", ops_done, exp_ops);
        run_op(4'b0000, 4'b0010, 1'b0, 1, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_add_sequencer.md
FP_ADD_SEQUENCER -- requirements
Module: fp_add_sequencer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-002 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset sampled on the clk rising edge.
REQ-003 The block SHALL have port in_valid, input, 1 bit, asserted when the operand pair is presented.
REQ-004 The block SHALL have port in_ready, output, 1 bit, asserted when the block can accept an operand pair.
REQ-005 The block SHALL have ports a_zero, a_inf, a_nan, a_snan, input, 1 bit each, carrying the operand-A classification flags.
REQ-006 The block SHALL have ports b_zero, b_inf, b_nan, b_snan, input, 1 bit each, carrying the operand-B classification flags.
REQ-007 The block SHALL have port eff_sub, input, 1 bit, asserted when the operand signs make the operation an effective subtraction.
REQ-008 The block SHALL have ports align_en, add_en, norm_en, round_en, output, 1 bit each, driving the datapath stage enables.
REQ-009 The block SHALL have port norm_done, input, 1 bit, asserted when the normalizer reports the leading one in position.
REQ-010 The block SHALL have port result_sel, output, 2 bits: 00 = datapath result, 01 = quiet NaN, 10 = infinity, 11 = zero.
REQ-011 The block SHALL have port invalid, output, 1 bit, the IEEE invalid-operation flag, valid while out_valid is high.
REQ-012 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), forming the result handshake.
REQ-013 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-014 The block SHALL have port ops_done, output, 16 bits, counting completed results.

Function
REQ-015 The FSM SHALL have states IDLE, CLASSIFY, ALIGN, ADD, NORM, ROUND, DONE.
REQ-016 in_ready SHALL be high only in IDLE; in_valid and in_ready both high at a clock edge latches all 8 flags and eff_sub and moves the FSM to CLASSIFY.
REQ-017 In CLASSIFY (one cycle), evaluation SHALL be in priority order: any snan -> result_sel=01, invalid=1; else any nan -> 01; else a_inf and b_inf and eff_sub -> 01, invalid=1; else any inf -> 10; else a_zero and b_zero -> 11; else -> 00.
REQ-018 From CLASSIFY, result_sel!=00 SHALL go to DONE; result_sel=00 SHALL go to ALIGN.
REQ-019 ALIGN, ADD and ROUND SHALL each last exactly one cycle, asserting align_en, add_en and round_en respectively only in that state; the sequence is ALIGN->ADD->NORM and ROUND->DONE.
REQ-020 NORM SHALL assert norm_en every cycle; a 5-bit norm_cnt clears on entry and increments each NORM cycle; the FSM exits to ROUND when norm_done=1 or norm_cnt=23, i.e. 24 NORM cycles maximum.
REQ-021 All stage enables SHALL be one-hot or zero in every cycle.
REQ-022 In DONE, out_valid SHALL be 1 and result_sel and invalid SHALL be held stable until out_ready=1; at that edge the FSM goes to IDLE and ops_done increments, wrapping from 0xFFFF to 0x0000.
REQ-023 The latency from input handshake to out_valid SHALL be 2 cycles on a special path and 5+N cycles on the normal path, where N is the number of NORM cycles (1..24).
REQ-024 A new input SHALL NOT be accepted in the cycle of the output handshake; in_ready rises in the following IDLE cycle.
REQ-025 in_valid and flag changes while busy=1 SHALL be ignored.

Reset
REQ-026 With reset high at a clock edge, the FSM SHALL go to IDLE from any state, including mid-NORM or DONE with out_valid pending, and the pending result is discarded.
REQ-027 Reset values SHALL be: in_ready=1 (in IDLE), out_valid=0, busy=0, all enables 0, result_sel=00, invalid=0, norm_cnt=0, ops_done=0.

Verification
REQ-028 Normal add: handshake with all flags 0 and norm_done=1 on the first NORM cycle -> out_valid at cycle 6, result_sel=00, invalid=0, enables seen in order align, add, norm, round.
REQ-029 a_snan=1 and b_inf=1 -> out_valid 2 cycles after the handshake, result_sel=01, invalid=1, no stage enable ever high.
REQ-030 a_inf=b_inf=1 with eff_sub=1 -> result_sel=01, invalid=1; the same with eff_sub=0 -> result_sel=10, invalid=0.
REQ-031 norm_done held 0 -> exactly 24 norm_en cycles, then round_en, out_valid at cycle 29.
REQ-032 out_ready held 0 for 5 cycles in DONE -> out_valid and result_sel stable throughout, ops_done increments once on release; preload ops_done to 0xFFFF and complete one op -> 0x0000.
REQ-033 Reset asserted during the 3rd NORM cycle -> next cycle IDLE, out_valid=0, in_ready=1, ops_done unchanged only if no prior reset, otherwise 0 per REQ-027.
